s2_operand_latch: RTL and testbench

// - S1->S2 pipeline stage directly downstream of the register file: registers both

---
 rtl/s2_operand_latch_if.sv | 47 ++++
 rtl/s2_operand_latch.sv | 152 +++++++++++++++
 tb/tb_s2_operand_latch.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/s2_operand_latch_if.sv
// Bundle of S1 (issue + register-file read), S3 writeback and S2 (execute-facing) signals
// around the S2 operand latch. The slave modport is the latch's own view.
interface s2_operand_latch_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int IMM_W  = 16,
  parameter int OPC_W  = 6,
  parameter int CNT_W  = 16
);
  logic              S1_Valid;
  logic              S1_Ready;
  logic              S1_Flush;
  logic [ADDR_W-1:0] S1_ReadSelect1;
  logic [ADDR_W-1:0] S1_ReadSelect2;
  logic [DATA_W-1:0] RF_ReadData1;
  logic [DATA_W-1:0] RF_ReadData2;
  logic [IMM_W-1:0]  S1_Imm;
  logic [OPC_W-1:0]  S1_Opcode;
  logic [ADDR_W-1:0] S1_DestSelect;
  logic [DATA_W-1:0] S3_WriteData;
  logic [ADDR_W-1:0] S3_WriteSelect;
  logic              S3_WriteEnable;
  logic              S2_Valid;
  logic              S2_Ready;
  logic [DATA_W-1:0] S2_Operand1;
  logic [DATA_W-1:0] S2_Operand2;
  logic [IMM_W-1:0]  S2_Imm;
  logic [OPC_W-1:0]  S2_Opcode;
  logic [ADDR_W-1:0] S2_DestSelect;
  logic [CNT_W-1:0]  S2_StallCount;

  modport slave (
    input  S1_Valid, S1_Flush, S1_ReadSelect1, S1_ReadSelect2,
    input  RF_ReadData1, RF_ReadData2, S1_Imm, S1_Opcode, S1_DestSelect,
    input  S3_WriteData, S3_WriteSelect, S3_WriteEnable, S2_Ready,
    output S1_Ready, S2_Valid, S2_Operand1, S2_Operand2, S2_Imm,
    output S2_Opcode, S2_DestSelect, S2_StallCount
  );

  modport master (
    output S1_Valid, S1_Flush, S1_ReadSelect1, S1_ReadSelect2,
    output RF_ReadData1, RF_ReadData2, S1_Imm, S1_Opcode, S1_DestSelect,
    output S3_WriteData, S3_WriteSelect, S3_WriteEnable, S2_Ready,
    input  S1_Ready, S2_Valid, S2_Operand1, S2_Operand2, S2_Imm,
    input  S2_Opcode, S2_DestSelect, S2_StallCount
  );
endinterface

// File: rtl/s2_operand_latch.sv
// S1->S2 single-entry operand latch with S3 writeback bypass on capture and while stalled.
// Optional stall-cycle counter enabled by defining S2_PERF_CNT_EN.
module s2_operand_latch #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int IMM_W  = 16,
  parameter int OPC_W  = 6,
  parameter int CNT_W  = 16
) (
  input logic clk,
  input logic rst_n,
  s2_operand_latch_if.slave bus
);

  logic              valid;
  logic [DATA_W-1:0] operand1;
  logic [DATA_W-1:0] operand2;
  logic [IMM_W-1:0]  imm;
  logic [OPC_W-1:0]  opcode;
  logic [ADDR_W-1:0] destSel;
  logic [ADDR_W-1:0] heldSel1;
  logic [ADDR_W-1:0] heldSel2;

  logic              s1Ready;
  logic              capture;
  logic              stall;
  logic              refresh1;
  logic              refresh2;
  logic              validNext;
  logic [DATA_W-1:0] captureOp1;
  logic [DATA_W-1:0] captureOp2;
  logic [DATA_W-1:0] operand1Next;
  logic [DATA_W-1:0] operand2Next;

  // Handshake decode, capture-time bypass, stall refresh and next-state selection
  always_comb begin
    s1Ready      = !valid || bus.S2_Ready;
    capture      = bus.S1_Valid && s1Ready && !bus.S1_Flush;
    stall        = valid && !bus.S2_Ready;
    captureOp1   = bus.RF_ReadData1;
    captureOp2   = bus.RF_ReadData2;
    refresh1     = 1'b0;
    refresh2     = 1'b0;
    validNext    = valid;
    operand1Next = operand1;
    operand2Next = operand2;

    // Register 0 is bypassed like any other register
    if (bus.S3_WriteEnable && (bus.S3_WriteSelect == bus.S1_ReadSelect1)) begin
      captureOp1 = bus.S3_WriteData;
    end else begin
      captureOp1 = bus.RF_ReadData1;
    end
    if (bus.S3_WriteEnable && (bus.S3_WriteSelect == bus.S1_ReadSelect2)) begin
      captureOp2 = bus.S3_WriteData;
    end else begin
      captureOp2 = bus.RF_ReadData2;
    end

    // Flush suppresses refresh as well as capture
    refresh1 = stall && !bus.S1_Flush && bus.S3_WriteEnable && (bus.S3_WriteSelect == heldSel1);
    refresh2 = stall && !bus.S1_Flush && bus.S3_WriteEnable && (bus.S3_WriteSelect == heldSel2);

    if (capture) begin
      operand1Next = captureOp1;
    end else if (refresh1) begin
      operand1Next = bus.S3_WriteData;
    end else begin
      operand1Next = operand1;
    end
    if (capture) begin
      operand2Next = captureOp2;
    end else if (refresh2) begin
      operand2Next = bus.S3_WriteData;
    end else begin
      operand2Next = operand2;
    end

    if (bus.S1_Flush) begin
      validNext = 1'b0;
    end else if (capture) begin
      validNext = 1'b1;
    end else if (bus.S2_Ready) begin
      validNext = 1'b0;
    end else begin
      validNext = valid;
    end
  end

  // Entry valid flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
    end else begin
      valid <= validNext;
    end
  end

  // Operand registers: loaded on capture or stall refresh, otherwise held
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      operand1 <= {DATA_W{1'b0}};
      operand2 <= {DATA_W{1'b0}};
    end else begin
      operand1 <= operand1Next;
      operand2 <= operand2Next;
    end
  end

  // Side-band fields and source selects: loaded on capture only
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imm      <= {IMM_W{1'b0}};
      opcode   <= {OPC_W{1'b0}};
      destSel  <= {ADDR_W{1'b0}};
      heldSel1 <= {ADDR_W{1'b0}};
      heldSel2 <= {ADDR_W{1'b0}};
    end else if (capture) begin
      imm      <= bus.S1_Imm;
      opcode   <= bus.S1_Opcode;
      destSel  <= bus.S1_DestSelect;
      heldSel1 <= bus.S1_ReadSelect1;
      heldSel2 <= bus.S1_ReadSelect2;
    end
  end

  assign bus.S1_Ready      = s1Ready;
  assign bus.S2_Valid      = valid;
  assign bus.S2_Operand1   = operand1;
  assign bus.S2_Operand2   = operand2;
  assign bus.S2_Imm        = imm;
  assign bus.S2_Opcode     = opcode;
  assign bus.S2_DestSelect = destSel;

`ifdef S2_PERF_CNT_EN
  logic [CNT_W-1:0] stallCount;

  // Saturating count of cycles spent holding an entry the execute stage refuses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stallCount <= {CNT_W{1'b0}};
    end else if (stall && (stallCount != {CNT_W{1'b1}})) begin
      stallCount <= stallCount + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign bus.S2_StallCount = stallCount;
`else
  assign bus.S2_StallCount = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_s2_operand_latch.sv
// Scoreboard bench for s2_operand_latch: stimulus pushes hand-computed entries,
// a monitor pops and compares on every S2 handshake.
module tb_s2_operand_latch;

  logic clk;
  logic rst_n;

  s2_operand_latch_if bus ();

  s2_operand_latch dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] op1;
    logic [31:0] op2;
    logic [15:0] imm;
    logic [5:0]  opc;
    logic [4:0]  dest;
  } exp_t;

  exp_t expQ[$];
  int   checks = 0;
  int   errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic checkStall(input logic [15:0] exp);
`ifdef S2_PERF_CNT_EN
    check("stall_count", {16'h0000, bus.S2_StallCount}, {16'h0000, exp});
`else
    check("stall_count_tied", {16'h0000, bus.S2_StallCount}, 32'h0000_0000);
`endif
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.S1_Valid       = 1'b0;
    bus.S1_Flush       = 1'b0;
    bus.S3_WriteEnable = 1'b0;
  endtask

  task automatic issue(input logic [4:0] s1, input logic [4:0] s2, input logic [31:0] d1,
                       input logic [31:0] d2, input logic [15:0] im, input logic [5:0] op,
                       input logic [4:0] ds);
    bus.S1_Valid       = 1'b1;
    bus.S1_ReadSelect1 = s1;
    bus.S1_ReadSelect2 = s2;
    bus.RF_ReadData1   = d1;
    bus.RF_ReadData2   = d2;
    bus.S1_Imm         = im;
    bus.S1_Opcode      = op;
    bus.S1_DestSelect  = ds;
  endtask

  task automatic s3Write(input logic [4:0] sel, input logic [31:0] data);
    bus.S3_WriteEnable = 1'b1;
    bus.S3_WriteSelect = sel;
    bus.S3_WriteData   = data;
  endtask

  task automatic expect_entry(input logic [31:0] o1, input logic [31:0] o2, input logic [15:0] im,
                              input logic [5:0] op, input logic [4:0] ds);
    exp_t e;
    e.op1 = o1; e.op2 = o2; e.imm = im; e.opc = op; e.dest = ds;
    expQ.push_back(e);
  endtask

  // Monitor: every accepted S2 transfer must match the oldest expected entry
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.S2_Valid && bus.S2_Ready) begin
        if (expQ.size() == 0) begin
          check("unexpected_s2_transfer", 32'd1, 32'd0);
        end else begin
          e = expQ.pop_front();
          check("s2_operand1", bus.S2_Operand1, e.op1);
          check("s2_operand2", bus.S2_Operand2, e.op2);
          check("s2_imm", {16'h0000, bus.S2_Imm}, {16'h0000, e.imm});
          check("s2_opcode", {26'd0, bus.S2_Opcode}, {26'd0, e.opc});
          check("s2_dest", {27'd0, bus.S2_DestSelect}, {27'd0, e.dest});
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    bus.S2_Ready = 1'b1;
    bus.S1_ReadSelect1 = 5'd0; bus.S1_ReadSelect2 = 5'd0;
    bus.RF_ReadData1 = 32'd0;  bus.RF_ReadData2 = 32'd0;
    bus.S1_Imm = 16'd0; bus.S1_Opcode = 6'd0; bus.S1_DestSelect = 5'd0;
    bus.S3_WriteSelect = 5'd0; bus.S3_WriteData = 32'd0;
    idle();
    repeat (2) nextCycle();

    // Reset state
    check("rst_valid", {31'd0, bus.S2_Valid}, 32'd0);
    check("rst_s1_ready", {31'd0, bus.S1_Ready}, 32'd1);
    check("rst_operand1", bus.S2_Operand1, 32'd0);
    check("rst_operand2", bus.S2_Operand2, 32'd0);
    checkStall(16'd0);
    rst_n = 1'b1;
    nextCycle();

    // T2 plain capture
    issue(5'd3, 5'd4, 32'h11, 32'h22, 16'h1234, 6'h2A, 5'd7);
    expect_entry(32'h11, 32'h22, 16'h1234, 6'h2A, 5'd7);
    nextCycle();
    check("t2_valid", {31'd0, bus.S2_Valid}, 32'd1);

    // T3 capture bypass on operand 1 only
    issue(5'd3, 5'd5, 32'h11, 32'h33, 16'h0042, 6'h05, 5'd9);
    s3Write(5'd3, 32'hAB);
    expect_entry(32'hAB, 32'h33, 16'h0042, 6'h05, 5'd9);
    nextCycle();

    // T4 stall refresh: capture A, then stall three cycles
    idle();
    issue(5'd1, 5'd4, 32'h100, 32'h200, 16'h00A5, 6'h11, 5'd1);
    expect_entry(32'h77, 32'h55, 16'h00A5, 6'h11, 5'd1);
    nextCycle();
    idle();
    bus.S2_Ready = 1'b0;
    s3Write(5'd4, 32'h55);
    #1;
    check("t4_s1_ready_stalled", {31'd0, bus.S1_Ready}, 32'd0);
    nextCycle();
    idle();
    issue(5'd1, 5'd4, 32'hBAD, 32'hBAD, 16'hFFFF, 6'h3F, 5'd31);
    check("t4_valid_held", {31'd0, bus.S2_Valid}, 32'd1);
    check("t4_operand2_refreshed", bus.S2_Operand2, 32'h55);
    nextCycle();
    idle();
    s3Write(5'd1, 32'h77);
    check("t4_operand1_not_captured", bus.S2_Operand1, 32'h100);
    nextCycle();
    idle();
    checkStall(16'd3);

    // Consume A and capture B in the same cycle; B refreshed on both operands
    bus.S2_Ready = 1'b1;
    issue(5'd6, 5'd6, 32'h60, 32'h61, 16'h0B0B, 6'h0B, 5'd6);
    expect_entry(32'h66, 32'h66, 16'h0B0B, 6'h0B, 5'd6);
    nextCycle();
    idle();
    bus.S2_Ready = 1'b0;
    s3Write(5'd6, 32'h66);
    nextCycle();
    idle();
    checkStall(16'd4);

    // T5 back-to-back, first instruction bypasses register 0
    bus.S2_Ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      idle();
      issue(i[4:0], i[4:0] + 5'd8, 32'h1000 + i, 32'h2000 + i, i[15:0], i[5:0] + 6'd1, i[4:0] + 5'd10);
      if (i == 0) s3Write(5'd0, 32'hDEAD);
      expect_entry((i == 0) ? 32'hDEAD : 32'h1000 + i, 32'h2000 + i, i[15:0], i[5:0] + 6'd1, i[4:0] + 5'd10);
      nextCycle();
      check("t5_no_bubble", {31'd0, bus.S2_Valid}, 32'd1);
    end
    idle();
    nextCycle();
    check("t5_drained", {31'd0, bus.S2_Valid}, 32'd0);
    check("t5_data_held_after_consume", bus.S2_Operand2, 32'h2003);

    // T6 flush a held entry while S1 presents a new one
    issue(5'd2, 5'd2, 32'h900, 32'h901, 16'h0006, 6'h06, 5'd6);
    bus.S2_Ready = 1'b0;
    nextCycle();
    idle();
    issue(5'd7, 5'd8, 32'h777, 32'h888, 16'h0007, 6'h07, 5'd7);
    bus.S1_Flush = 1'b1;
    #1;
    check("t6_ready_ignores_flush", {31'd0, bus.S1_Ready}, 32'd0);
    nextCycle();
    check("t6_flushed", {31'd0, bus.S2_Valid}, 32'd0);
    check("t6_empty_ready", {31'd0, bus.S1_Ready}, 32'd1);
    nextCycle();
    check("t6_flush_blocks_capture", {31'd0, bus.S2_Valid}, 32'd0);
    checkStall(16'd5);

    // T1 asynchronous reset while an entry is stalled
    idle();
    bus.S2_Ready = 1'b1;
    issue(5'd3, 5'd4, 32'hCAFE, 32'hBEEF, 16'h00C0, 6'h0C, 5'd12);
    nextCycle();
    idle();
    bus.S2_Ready = 1'b0;
    nextCycle();
    check("t1_pre_reset_valid", {31'd0, bus.S2_Valid}, 32'd1);
    checkStall(16'd6);
    #2;
    rst_n = 1'b0;
    #1;
    check("t1_valid", {31'd0, bus.S2_Valid}, 32'd0);
    check("t1_operand1", bus.S2_Operand1, 32'd0);
    check("t1_operand2", bus.S2_Operand2, 32'd0);
    check("t1_imm", {16'h0000, bus.S2_Imm}, 32'd0);
    check("t1_opcode", {26'd0, bus.S2_Opcode}, 32'd0);
    check("t1_dest", {27'd0, bus.S2_DestSelect}, 32'd0);
    checkStall(16'd0);
    nextCycle();
    rst_n = 1'b1;
    bus.S2_Ready = 1'b1;
    repeat (3) nextCycle();
    check("t1_no_replay", {31'd0, bus.S2_Valid}, 32'd0);
    check("scoreboard_drained", expQ.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
